// File: rtl/qracc_pkg.sv
// Shared types for the QRAcc SRAM access sequencer: FSM states and the
// default phase-timing triple used when bringing up the macro.
package qracc_pkg;

    localparam int unsigned SRAM_CFG_W = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PRECH = 3'd1,
        WLON  = 3'd2,
        SENSE = 3'd3,
        DONE  = 3'd4
    } sram_seq_state_t;

    typedef struct packed {
        logic [SRAM_CFG_W-1:0] pch;
        logic [SRAM_CFG_W-1:0] wl;
        logic [SRAM_CFG_W-1:0] sa;
    } sram_timing_cfg_t;

    localparam sram_timing_cfg_t SRAM_TIMING_DEFAULT = '{pch: 4'd1, wl: 4'd2, sa: 4'd1};

endpackage

// File: rtl/phase_counter.sv
// Down-counter shared by all access phases: reloaded on each phase entry,
// a zero length behaves as one cycle, done is high on the final cycle.
module phase_counter #(
    parameter int unsigned phaseBits = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [phaseBits-1:0] load_val,
    output logic                 done
);

    logic [phaseBits-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= (load_val == '0) ? phaseBits'(1) : load_val;
        end else if (cnt_q > phaseBits'(1)) begin
            cnt_q <= cnt_q - phaseBits'(1);
        end
    end

    assign done = (cnt_q <= phaseBits'(1));

endmodule

// File: rtl/qracc_sram_sequencer.sv
// SRAM access sequencer: turns accepted read/write requests into a registered
// precharge / wordline / write-drive or sense / capture pulse train.
module qracc_sram_sequencer
    import qracc_pkg::*;
#(
    parameter int unsigned numRows   = 128,
    parameter int unsigned numCols   = 32,
    parameter int unsigned phaseBits = 4,
    parameter int unsigned addrBits  = $clog2(numRows)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rq_valid_i,
    input  logic                 rq_wr_i,
    input  logic [addrBits-1:0]  addr_i,
    input  logic [numCols-1:0]   wr_data_i,
    input  logic [numCols-1:0]   wr_mask_i,
    input  logic [phaseBits-1:0] cfg_pch_cycles_i,
    input  logic [phaseBits-1:0] cfg_wl_cycles_i,
    input  logic [phaseBits-1:0] cfg_sa_cycles_i,
    output logic                 rq_ready_o,
    output logic                 rd_valid_o,
    output logic [numCols-1:0]   rd_data_o,
    output logic                 err_o,
    output logic                 busy_o,
    input  logic [numCols-1:0]   SA_OUT,
    output logic                 PCH,
    output logic [numRows-1:0]   WL,
    output logic                 WRITE,
    output logic [numCols-1:0]   WR_DATA,
    output logic [numCols-1:0]   CSEL,
    output logic                 SAEN
);

    sram_seq_state_t state_q, state_d;

    logic                 wr_q;
    logic [addrBits-1:0]  addr_q;
    logic [numCols-1:0]   data_q;
    logic [numCols-1:0]   mask_q;
    logic [phaseBits-1:0] wl_len_q;
    logic [phaseBits-1:0] sa_len_q;

    logic                 accept;
    logic                 addr_err;
    logic                 cnt_load;
    logic [phaseBits-1:0] cnt_val;
    logic                 cnt_done;

    logic                 pch_d;
    logic [numRows-1:0]   wl_d;
    logic                 write_d;
    logic [numCols-1:0]   wr_data_d;
    logic [numCols-1:0]   csel_d;
    logic                 saen_d;
    logic                 rd_valid_d;
    logic                 err_d;
    logic                 ready_d;

    assign accept   = rq_valid_i && rq_ready_o;
    assign addr_err = ({1'b0, addr_i} >= (addrBits + 1)'(numRows));
    assign busy_o   = (state_q != IDLE);

    phase_counter #(
        .phaseBits (phaseBits)
    ) u_phase_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .done     (cnt_done)
    );

    // PRECH length is loaded straight from the request inputs on the accept
    // edge; later phases reload from the latched copies.
    always_comb begin
        state_d  = state_q;
        cnt_load = 1'b0;
        cnt_val  = cfg_pch_cycles_i;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (addr_err) begin
                        state_d = DONE;
                    end else begin
                        state_d  = PRECH;
                        cnt_load = 1'b1;
                        cnt_val  = cfg_pch_cycles_i;
                    end
                end
            end
            PRECH: begin
                if (cnt_done) begin
                    state_d  = WLON;
                    cnt_load = 1'b1;
                    cnt_val  = wl_len_q;
                end
            end
            WLON: begin
                if (cnt_done) begin
                    if (wr_q) begin
                        state_d = DONE;
                    end else begin
                        state_d  = SENSE;
                        cnt_load = 1'b1;
                        cnt_val  = sa_len_q;
                    end
                end
            end
            SENSE: begin
                if (cnt_done) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the pin registers switch on
    // the same edge as the state register.
    always_comb begin
        pch_d      = (state_d == PRECH);
        saen_d     = (state_d == SENSE);
        write_d    = (state_d == WLON) && wr_q;
        wl_d       = '0;
        if ((state_d == WLON) || (state_d == SENSE)) begin
            for (int unsigned r = 0; r < numRows; r++) begin
                wl_d[r] = (addr_q == addrBits'(r));
            end
        end
        wr_data_d  = write_d ? data_q : '0;
        if (write_d) begin
            csel_d = mask_q;
        end else if ((state_d == WLON) || (state_d == SENSE)) begin
            csel_d = '1;
        end else begin
            csel_d = '0;
        end
        rd_valid_d = (state_q == SENSE) && (state_d == DONE);
        err_d      = (state_q == IDLE) && (state_d == DONE);
        ready_d    = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            mask_q     <= '0;
            wl_len_q   <= '0;
            sa_len_q   <= '0;
            rq_ready_o <= 1'b0;
            rd_valid_o <= 1'b0;
            rd_data_o  <= '0;
            err_o      <= 1'b0;
            PCH        <= 1'b0;
            WL         <= '0;
            WRITE      <= 1'b0;
            WR_DATA    <= '0;
            CSEL       <= '0;
            SAEN       <= 1'b0;
        end else begin
            state_q    <= state_d;
            rq_ready_o <= ready_d;
            rd_valid_o <= rd_valid_d;
            err_o      <= err_d;
            PCH        <= pch_d;
            WL         <= wl_d;
            WRITE      <= write_d;
            WR_DATA    <= wr_data_d;
            CSEL       <= csel_d;
            SAEN       <= saen_d;
            if (accept) begin
                wr_q     <= rq_wr_i;
                addr_q   <= addr_i;
                data_q   <= wr_data_i;
                mask_q   <= wr_mask_i;
                wl_len_q <= cfg_wl_cycles_i;
                sa_len_q <= cfg_sa_cycles_i;
            end
            if ((state_q == SENSE) && cnt_done) begin
                rd_data_o <= SA_OUT;
            end
        end
    end

    // Only the wordline may overlap the write drivers or the sense amps.
    assert property (@(posedge clk) disable iff (rst) !(PCH && (WRITE || SAEN || (|WL))));
    assert property (@(posedge clk) disable iff (rst) !(WRITE && SAEN));
    assert property (@(posedge clk) disable iff (rst) $onehot0(WL));

endmodule

// File: tb/tb_qracc_sram_sequencer.sv
// Bench for qracc_sram_sequencer: a 128-row and a 96-row instance share stimulus;
// expected pin activity is derived per cycle from the phase lengths.
`timescale 1ns/1ps
module tb_qracc_sram_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        rq_valid_i, rq_wr_i;
    logic [6:0]  addr_i;
    logic [31:0] wr_data_i, wr_mask_i, SA_OUT;
    logic [3:0]  cfg_pch_cycles_i, cfg_wl_cycles_i, cfg_sa_cycles_i;

    logic         a_rq_ready, a_rd_valid, a_err, a_busy, a_pch, a_write, a_saen;
    logic [31:0]  a_rd_data, a_wr_data, a_csel;
    logic [127:0] a_wl;
    logic         b_rq_ready, b_rd_valid, b_err, b_busy, b_pch, b_write, b_saen;
    logic [31:0]  b_rd_data, b_wr_data, b_csel;
    logic [95:0]  b_wl;

    always #5 clk = ~clk;

    qracc_sram_sequencer #(.numRows(128), .numCols(32), .phaseBits(4)) dut128 (
        .clk(clk), .rst(rst), .rq_valid_i(rq_valid_i), .rq_wr_i(rq_wr_i), .addr_i(addr_i),
        .wr_data_i(wr_data_i), .wr_mask_i(wr_mask_i), .cfg_pch_cycles_i(cfg_pch_cycles_i),
        .cfg_wl_cycles_i(cfg_wl_cycles_i), .cfg_sa_cycles_i(cfg_sa_cycles_i),
        .rq_ready_o(a_rq_ready), .rd_valid_o(a_rd_valid), .rd_data_o(a_rd_data), .err_o(a_err),
        .busy_o(a_busy), .SA_OUT(SA_OUT), .PCH(a_pch), .WL(a_wl), .WRITE(a_write),
        .WR_DATA(a_wr_data), .CSEL(a_csel), .SAEN(a_saen));

    qracc_sram_sequencer #(.numRows(96), .numCols(32), .phaseBits(4)) dut96 (
        .clk(clk), .rst(rst), .rq_valid_i(rq_valid_i), .rq_wr_i(rq_wr_i), .addr_i(addr_i),
        .wr_data_i(wr_data_i), .wr_mask_i(wr_mask_i), .cfg_pch_cycles_i(cfg_pch_cycles_i),
        .cfg_wl_cycles_i(cfg_wl_cycles_i), .cfg_sa_cycles_i(cfg_sa_cycles_i),
        .rq_ready_o(b_rq_ready), .rd_valid_o(b_rd_valid), .rd_data_o(b_rd_data), .err_o(b_err),
        .busy_o(b_busy), .SA_OUT(SA_OUT), .PCH(b_pch), .WL(b_wl), .WRITE(b_write),
        .WR_DATA(b_wr_data), .CSEL(b_csel), .SAEN(b_saen));

    typedef struct packed {
        logic         pch;
        logic [127:0] wl;
        logic         write;
        logic [31:0]  wr_data;
        logic [31:0]  csel;
        logic         saen;
        logic         rd_valid;
        logic [31:0]  rd_data;
        logic         err;
        logic         busy;
        logic         ready;
    } obs_t;

    typedef struct packed {
        logic        wr;
        logic [6:0]  addr;
        logic [31:0] data;
        logic [31:0] mask;
        logic [3:0]  pch;
        logic [3:0]  wl;
        logic [3:0]  sa;
    } txn_t;

    int          passed = 0;
    int          total  = 0;
    logic [31:0] model_rd;
    obs_t        obs_a [64];
    obs_t        obs_b [64];
    logic [31:0] sa_drv [64];

    function automatic obs_t sample_a();
        obs_t o;
        o.pch = a_pch; o.wl = a_wl; o.write = a_write; o.wr_data = a_wr_data; o.csel = a_csel;
        o.saen = a_saen; o.rd_valid = a_rd_valid; o.rd_data = a_rd_data; o.err = a_err;
        o.busy = a_busy; o.ready = a_rq_ready;
        return o;
    endfunction

    function automatic obs_t sample_b();
        obs_t o;
        o.pch = b_pch; o.wl = {32'b0, b_wl}; o.write = b_write; o.wr_data = b_wr_data; o.csel = b_csel;
        o.saen = b_saen; o.rd_valid = b_rd_valid; o.rd_data = b_rd_data; o.err = b_err;
        o.busy = b_busy; o.ready = b_rq_ready;
        return o;
    endfunction

    function automatic int eff(input logic [3:0] x);
        return (x == 4'd0) ? 1 : int'(x);
    endfunction

    // Cycle (counted from the accept edge) in which DONE is shown.
    function automatic int txn_done(input txn_t t, input int nrows);
        if (int'(t.addr) >= nrows) return 1;
        return eff(t.pch) + eff(t.wl) + (t.wr ? 0 : eff(t.sa)) + 1;
    endfunction

    function automatic logic [31:0] capture_of(input txn_t t);
        return sa_drv[eff(t.pch) + eff(t.wl) + eff(t.sa)];
    endfunction

    function automatic obs_t model(input int k, input txn_t t, input int nrows,
                                   input logic [31:0] sa_cap, input logic [31:0] rd_hold);
        obs_t e;
        int   p, w, s, td;
        bit   bad;
        e = '0;
        p = eff(t.pch); w = eff(t.wl); s = eff(t.sa);
        bad = (int'(t.addr) >= nrows);
        td = txn_done(t, nrows);
        e.rd_data = rd_hold;
        if (k <= td) e.busy = 1'b1; else e.ready = 1'b1;
        if (!bad) begin
            if (k <= p) begin
                e.pch = 1'b1;
            end else if (k <= p + w) begin
                e.wl[t.addr] = 1'b1;
                if (t.wr) begin
                    e.write = 1'b1; e.wr_data = t.data; e.csel = t.mask;
                end else begin
                    e.csel = '1;
                end
            end else if (!t.wr && k <= p + w + s) begin
                e.wl[t.addr] = 1'b1; e.saen = 1'b1; e.csel = '1;
            end
            if (!t.wr && k >= td) e.rd_data = sa_cap;
        end
        if (k == td) begin
            if (bad) e.err = 1'b1;
            else if (!t.wr) e.rd_valid = 1'b1;
        end
        return e;
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (!(a_rq_ready && b_rq_ready) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        total++;
        if (a_rq_ready && b_rq_ready) passed++;
        else $display("FAIL wait_ready: ready a=%0b b=%0b after %0d cycles, required 1/1", a_rq_ready, b_rq_ready, n);
    endtask

    // Presents t in a ready cycle, then records both instances for len cycles
    // while scrambling every request input (valid held per hold_valid).
    task automatic drive_txn(input txn_t t, input bit hold_valid, input int len);
        wait_ready();
        rq_valid_i = 1'b1; rq_wr_i = t.wr; addr_i = t.addr; wr_data_i = t.data; wr_mask_i = t.mask;
        cfg_pch_cycles_i = t.pch; cfg_wl_cycles_i = t.wl; cfg_sa_cycles_i = t.sa;
        SA_OUT = $urandom; sa_drv[0] = SA_OUT;
        @(posedge clk); #1;
        for (int k = 1; k <= len; k++) begin
            obs_a[k] = sample_a();
            obs_b[k] = sample_b();
            if (k < len) begin
                rq_valid_i = hold_valid; rq_wr_i = 1'($urandom); addr_i = 7'($urandom);
                wr_data_i = $urandom; wr_mask_i = $urandom;
                cfg_pch_cycles_i = 4'($urandom); cfg_wl_cycles_i = 4'($urandom); cfg_sa_cycles_i = 4'($urandom);
                SA_OUT = $urandom; sa_drv[k] = SA_OUT;
                @(posedge clk); #1;
            end
        end
    endtask

    function automatic txn_t rand_txn();
        txn_t t;
        t.wr = 1'($urandom); t.addr = 7'($urandom_range(0, 95)); t.data = $urandom; t.mask = $urandom;
        t.pch = 4'($urandom); t.wl = 4'($urandom); t.sa = 4'($urandom);
        return t;
    endfunction

    task automatic test_reset();
        obs_t e;
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        e = '0;
        total++; if (sample_a() !== e) $display("FAIL reset_a: got %h want %h", sample_a(), e); else passed++;
        total++; if (sample_b() !== e) $display("FAIL reset_b: got %h want %h", sample_b(), e); else passed++;
        rst = 1'b0;
        @(posedge clk); #1;
        e.ready = 1'b1;
        total++; if (sample_a() !== e) $display("FAIL post_reset_a: got %h want %h", sample_a(), e); else passed++;
        total++; if (sample_b() !== e) $display("FAIL post_reset_b: got %h want %h", sample_b(), e); else passed++;
        model_rd = '0;
    endtask

    task automatic test_write_basic();
        txn_t t; obs_t e; int len;
        t.wr = 1'b1; t.addr = 7'd5; t.data = 32'hA5A5_0F0F; t.mask = '1;
        t.pch = qracc_pkg::SRAM_TIMING_DEFAULT.pch;
        t.wl  = qracc_pkg::SRAM_TIMING_DEFAULT.wl;
        t.sa  = qracc_pkg::SRAM_TIMING_DEFAULT.sa;
        len = txn_done(t, 128) + 1;
        drive_txn(t, 1'b0, len);
        for (int k = 1; k <= len; k++) begin
            e = model(k, t, 128, capture_of(t), model_rd);
            total++;
            if (obs_a[k] !== e) $display("FAIL write_basic c%0d: got %h want %h", k, obs_a[k], e);
            else passed++;
        end
    endtask

    task automatic test_read_basic();
        txn_t t; obs_t e; int len;
        t.wr = 1'b0; t.addr = 7'd5; t.data = $urandom; t.mask = $urandom;
        t.pch = 4'd2; t.wl = 4'd3; t.sa = 4'd2;
        len = txn_done(t, 128) + 1;
        drive_txn(t, 1'b0, len);
        for (int k = 1; k <= len; k++) begin
            e = model(k, t, 128, capture_of(t), model_rd);
            total++;
            if (obs_a[k] !== e) $display("FAIL read_basic c%0d: got %h want %h", k, obs_a[k], e);
            else passed++;
        end
        model_rd = capture_of(t);
    endtask

    task automatic test_zero_cfg();
        txn_t t; obs_t e; int len;
        t.wr = 1'b1; t.addr = 7'($urandom_range(0, 95)); t.data = $urandom; t.mask = 32'h0000_FFFF;
        t.pch = 4'd0; t.wl = 4'd0; t.sa = 4'd0;
        len = txn_done(t, 128) + 1;
        drive_txn(t, 1'b0, len);
        for (int k = 1; k <= len; k++) begin
            e = model(k, t, 128, capture_of(t), model_rd);
            total++;
            if (obs_a[k] !== e) $display("FAIL zero_cfg c%0d: got %h want %h", k, obs_a[k], e);
            else passed++;
        end
    endtask

    task automatic test_random();
        txn_t t; obs_t e; int len;
        for (int n = 0; n < 12; n++) begin
            t = rand_txn();
            len = txn_done(t, 128) + 1;
            drive_txn(t, 1'b0, len);
            for (int k = 1; k <= len; k++) begin
                e = model(k, t, 128, capture_of(t), model_rd);
                total++;
                if (obs_a[k] !== e) $display("FAIL random n%0d c%0d: got %h want %h", n, k, obs_a[k], e);
                else passed++;
            end
            if (!t.wr) model_rd = capture_of(t);
        end
    endtask

    task automatic test_back_to_back();
        txn_t t; obs_t e; int len;
        for (int n = 0; n < 3; n++) begin
            t = rand_txn();
            len = txn_done(t, 128) + 1;
            drive_txn(t, 1'b1, len);
            for (int k = 1; k <= len; k++) begin
                e = model(k, t, 128, capture_of(t), model_rd);
                total++;
                if (obs_a[k] !== e) $display("FAIL back_to_back n%0d c%0d: got %h want %h", n, k, obs_a[k], e);
                else passed++;
            end
            if (!t.wr) model_rd = capture_of(t);
        end
        rq_valid_i = 1'b0;
    endtask

    task automatic test_err96();
        txn_t t; obs_t e; int len;
        for (int n = 0; n < 2; n++) begin
            t = rand_txn();
            t.wr = 1'b0;
            t.addr = (n == 0) ? 7'd96 : 7'd100;
            len = txn_done(t, 96) + 1;
            drive_txn(t, 1'b0, len);
            for (int k = 1; k <= len; k++) begin
                e = model(k, t, 96, capture_of(t), model_rd);
                total++;
                if (obs_b[k] !== e) $display("FAIL err96 addr%0d c%0d: got %h want %h", t.addr, k, obs_b[k], e);
                else passed++;
            end
        end
    endtask

    task automatic test_reset_mid_read();
        txn_t t; obs_t e; int len;
        wait_ready();
        rq_valid_i = 1'b1; rq_wr_i = 1'b0; addr_i = 7'($urandom_range(0, 95));
        cfg_pch_cycles_i = 4'd1; cfg_wl_cycles_i = 4'd1; cfg_sa_cycles_i = 4'd4;
        SA_OUT = $urandom;
        @(posedge clk); #1;
        rq_valid_i = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        total++;
        if (a_saen !== 1'b1 || b_saen !== 1'b1) $display("FAIL mid_read_sense: saen a=%0b b=%0b want 1/1", a_saen, b_saen);
        else passed++;
        rst = 1'b1;
        @(posedge clk); #1;
        e = '0;
        total++; if (sample_a() !== e) $display("FAIL mid_reset_a: got %h want %h", sample_a(), e); else passed++;
        total++; if (sample_b() !== e) $display("FAIL mid_reset_b: got %h want %h", sample_b(), e); else passed++;
        rst = 1'b0;
        @(posedge clk); #1;
        e.ready = 1'b1;
        total++; if (sample_a() !== e) $display("FAIL mid_release_a: got %h want %h", sample_a(), e); else passed++;
        total++; if (sample_b() !== e) $display("FAIL mid_release_b: got %h want %h", sample_b(), e); else passed++;
        model_rd = '0;
        t = rand_txn();
        t.wr = 1'b0;
        len = txn_done(t, 128) + 1;
        drive_txn(t, 1'b0, len);
        for (int k = 1; k <= len; k++) begin
            e = model(k, t, 128, capture_of(t), model_rd);
            total++;
            if (obs_a[k] !== e) $display("FAIL fresh_read c%0d: got %h want %h", k, obs_a[k], e);
            else passed++;
        end
        model_rd = capture_of(t);
    endtask

    initial begin
        rst = 1'b1; rq_valid_i = 1'b0; rq_wr_i = 1'b0; addr_i = '0; wr_data_i = '0; wr_mask_i = '0;
        cfg_pch_cycles_i = '0; cfg_wl_cycles_i = '0; cfg_sa_cycles_i = '0; SA_OUT = '0;
        model_rd = '0;
        test_reset();
        test_write_basic();
        test_read_basic();
        test_zero_cfg();
        test_random();
        test_back_to_back();
        test_err96();
        test_reset_mid_read();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed so far", passed, total);
        $fatal(1);
    end

endmodule
